// File: rtl/control_pkg.sv
// Shared encodings for the multi-cycle control unit: FSM states, opcodes,
// opcode classes, mux select codes and the packed control word.
package control_pkg;

  typedef enum logic [3:0] {
    S_IDLE      = 4'd0,
    S_FETCH     = 4'd1,
    S_DECODE    = 4'd2,
    S_EXEC_R    = 4'd3,
    S_EXEC_ADDR = 4'd4,
    S_MEM       = 4'd5,
    S_WB_R      = 4'd6,
    S_WB_I      = 4'd7,
    S_WB_MEM    = 4'd8,
    S_BRANCH    = 4'd9,
    S_JUMP      = 4'd10
  } state_t;

  localparam logic [5:0] OP_R    = 6'd0;
  localparam logic [5:0] OP_LW   = 6'd1;
  localparam logic [5:0] OP_SW   = 6'd2;
  localparam logic [5:0] OP_BEQ  = 6'd3;
  localparam logic [5:0] OP_ADDI = 6'd4;
  localparam logic [5:0] OP_J    = 6'd5;

  typedef enum logic [2:0] {
    OPC_R    = 3'd0,
    OPC_LW   = 3'd1,
    OPC_SW   = 3'd2,
    OPC_BEQ  = 3'd3,
    OPC_ADDI = 3'd4,
    OPC_J    = 3'd5,
    OPC_ILL  = 3'd6
  } opclass_t;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  localparam logic [1:0] SRCB_REGB   = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH = 2'b11;

  typedef struct packed {
    logic       memreq;
    logic       memread;
    logic       memwrite;
    logic       iord;
    logic       irwrite;
    logic       pcwrite;
    logic       pcwritecond;
    logic [1:0] pcsource;
    logic       regwrite;
    logic       regdst;
    logic       memtoreg;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic [1:0] aluop;
    logic       illegal;
  } ctrl_t;

  function automatic opclass_t classify_op(input logic [5:0] op);
    opclass_t cls;
    case (op)
      OP_R:    cls = OPC_R;
      OP_LW:   cls = OPC_LW;
      OP_SW:   cls = OPC_SW;
      OP_BEQ:  cls = OPC_BEQ;
      OP_ADDI: cls = OPC_ADDI;
      OP_J:    cls = OPC_J;
      default: cls = OPC_ILL;
    endcase
    return cls;
  endfunction

endpackage

// File: rtl/control_output_decode.sv
// Combinational state -> control-word decode for the multi-cycle controller.
// The fetch-completion and memory-direction bits are qualified by the handshake and opcode class.
module control_output_decode
  import control_pkg::*;
(
  input  state_t   state,
  input  logic     mem_ready,
  input  opclass_t op_class,
  output ctrl_t    ctrl
);

  // Control word for the current state; everything not named stays 0.
  always_comb begin
    ctrl = '0;
    case (state)
      S_FETCH: begin
        ctrl.memreq  = 1'b1;
        ctrl.memread = 1'b1;
        ctrl.alusrcb = SRCB_FOUR;
        ctrl.aluop   = ALU_ADD;
        if (mem_ready) begin
          ctrl.irwrite  = 1'b1;
          ctrl.pcwrite  = 1'b1;
          ctrl.pcsource = PCSRC_ALU;
        end else begin
          ctrl.irwrite  = 1'b0;
          ctrl.pcwrite  = 1'b0;
        end
      end
      S_DECODE: begin
        ctrl.alusrcb = SRCB_IMM_SH;
        ctrl.aluop   = ALU_ADD;
        ctrl.illegal = (op_class == OPC_ILL);
      end
      S_EXEC_R: begin
        ctrl.alusrca = 1'b1;
        ctrl.alusrcb = SRCB_REGB;
        ctrl.aluop   = ALU_FUNCT;
      end
      S_EXEC_ADDR: begin
        ctrl.alusrca = 1'b1;
        ctrl.alusrcb = SRCB_IMM;
        ctrl.aluop   = ALU_ADD;
      end
      S_MEM: begin
        ctrl.memreq = 1'b1;
        ctrl.iord   = 1'b1;
        if (op_class == OPC_LW) begin
          ctrl.memread = 1'b1;
        end else if (op_class == OPC_SW) begin
          ctrl.memwrite = 1'b1;
        end else begin
          ctrl.memread  = 1'b0;
          ctrl.memwrite = 1'b0;
        end
      end
      S_WB_R: begin
        ctrl.regwrite = 1'b1;
        ctrl.regdst   = 1'b1;
      end
      S_WB_I: begin
        ctrl.regwrite = 1'b1;
      end
      S_WB_MEM: begin
        ctrl.regwrite = 1'b1;
        ctrl.memtoreg = 1'b1;
      end
      S_BRANCH: begin
        ctrl.alusrca     = 1'b1;
        ctrl.alusrcb     = SRCB_REGB;
        ctrl.aluop       = ALU_SUB;
        ctrl.pcwritecond = 1'b1;
        ctrl.pcsource    = PCSRC_ALUOUT;
      end
      S_JUMP: begin
        ctrl.pcwrite  = 1'b1;
        ctrl.pcsource = PCSRC_JUMP;
      end
      default: ctrl = '0;
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// Multi-cycle instruction sequencer: state register, next-state logic and control outputs.
// Optional INSTR_COUNT_EN adds a retired-instruction counter on port retiredCount.
module multicycle_control
  import control_pkg::*;
#(
  parameter int OPCODE_W = 6,
  parameter int ALUOP_W  = 2,
  parameter int COUNT_W  = 32
) (
  input  logic                clk,
  input  logic                resetN,
  input  logic [OPCODE_W-1:0] opCode,
  input  logic                memReady,
  output logic                memReq,
  output logic                memRead,
  output logic                memWrite,
  output logic                iorD,
  output logic                irWrite,
  output logic                pcWrite,
  output logic                pcWriteCond,
  output logic [1:0]          pcSource,
  output logic                regWrite,
  output logic                regDst,
  output logic                memToReg,
  output logic                aluSrcA,
  output logic [1:0]          aluSrcB,
  output logic [ALUOP_W-1:0]  aluOp,
  output logic                illegalOp
`ifdef INSTR_COUNT_EN
  ,
  output logic [COUNT_W-1:0]  retiredCount
`endif
);

  state_t   state_r;
  state_t   next_state_s;
  opclass_t opclass_s;
  ctrl_t    ctrl_s;

  assign opclass_s = classify_op(6'(opCode));

  // State register; reset returns to IDLE even mid-instruction.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_r <= S_IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next-state selection; memReady only matters in FETCH and MEM.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      S_IDLE:  next_state_s = S_FETCH;
      S_FETCH: begin
        if (memReady) begin
          next_state_s = S_DECODE;
        end else begin
          next_state_s = S_FETCH;
        end
      end
      S_DECODE: begin
        case (opclass_s)
          OPC_R:                     next_state_s = S_EXEC_R;
          OPC_LW, OPC_SW, OPC_ADDI:  next_state_s = S_EXEC_ADDR;
          OPC_BEQ:                   next_state_s = S_BRANCH;
          OPC_J:                     next_state_s = S_JUMP;
          default:                   next_state_s = S_FETCH;
        endcase
      end
      S_EXEC_R: next_state_s = S_WB_R;
      S_EXEC_ADDR: begin
        if (opclass_s == OPC_ADDI) begin
          next_state_s = S_WB_I;
        end else begin
          next_state_s = S_MEM;
        end
      end
      S_MEM: begin
        if (!memReady) begin
          next_state_s = S_MEM;
        end else if (opclass_s == OPC_LW) begin
          next_state_s = S_WB_MEM;
        end else begin
          next_state_s = S_FETCH;
        end
      end
      S_WB_R, S_WB_I, S_WB_MEM, S_BRANCH, S_JUMP: next_state_s = S_FETCH;
      default: next_state_s = S_IDLE;
    endcase
  end

  control_output_decode u_decode (
    .state     (state_r),
    .mem_ready (memReady),
    .op_class  (opclass_s),
    .ctrl      (ctrl_s)
  );

  assign memReq      = ctrl_s.memreq;
  assign memRead     = ctrl_s.memread;
  assign memWrite    = ctrl_s.memwrite;
  assign iorD        = ctrl_s.iord;
  assign irWrite     = ctrl_s.irwrite;
  assign pcWrite     = ctrl_s.pcwrite;
  assign pcWriteCond = ctrl_s.pcwritecond;
  assign pcSource    = ctrl_s.pcsource;
  assign regWrite    = ctrl_s.regwrite;
  assign regDst      = ctrl_s.regdst;
  assign memToReg    = ctrl_s.memtoreg;
  assign aluSrcA     = ctrl_s.alusrca;
  assign aluSrcB     = ctrl_s.alusrcb;
  assign aluOp       = ALUOP_W'(ctrl_s.aluop);
  assign illegalOp   = ctrl_s.illegal;

`ifdef INSTR_COUNT_EN
  logic               retire_s;
  logic [COUNT_W-1:0] count_r;

  // An instruction retires on its final transition back to FETCH.
  always_comb begin
    retire_s = 1'b0;
    case (state_r)
      S_WB_R, S_WB_I, S_WB_MEM, S_BRANCH, S_JUMP: retire_s = 1'b1;
      S_MEM:   retire_s = memReady && (opclass_s == OPC_SW);
      default: retire_s = 1'b0;
    endcase
  end

  // Retired-instruction counter, wrapping naturally.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      count_r <= {COUNT_W{1'b0}};
    end else if (retire_s) begin
      count_r <= count_r + {{(COUNT_W-1){1'b0}}, 1'b1};
    end else begin
      count_r <= count_r;
    end
  end

  assign retiredCount = count_r;
`endif

endmodule

// File: tb/tb_multicycle_control.sv
// Scoreboard bench for multicycle_control: stimulus pushes hand-built expected
// control words per cycle, a negedge monitor pops and compares them.
module tb_multicycle_control;

  logic       clk;
  logic       resetN;
  logic [5:0] opCode;
  logic       memReady;
  logic       memReq, memRead, memWrite, iorD, irWrite, pcWrite, pcWriteCond;
  logic [1:0] pcSource;
  logic       regWrite, regDst, memToReg, aluSrcA;
  logic [1:0] aluSrcB;
  logic [1:0] aluOp;
  logic       illegalOp;
`ifdef INSTR_COUNT_EN
  logic [31:0] retiredCount;
`endif

  multicycle_control dut (
    .clk         (clk),
    .resetN      (resetN),
    .opCode      (opCode),
    .memReady    (memReady),
    .memReq      (memReq),
    .memRead     (memRead),
    .memWrite    (memWrite),
    .iorD        (iorD),
    .irWrite     (irWrite),
    .pcWrite     (pcWrite),
    .pcWriteCond (pcWriteCond),
    .pcSource    (pcSource),
    .regWrite    (regWrite),
    .regDst      (regDst),
    .memToReg    (memToReg),
    .aluSrcA     (aluSrcA),
    .aluSrcB     (aluSrcB),
    .aluOp       (aluOp),
    .illegalOp   (illegalOp)
`ifdef INSTR_COUNT_EN
    ,
    .retiredCount(retiredCount)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Field order: memReq memRead memWrite iorD irWrite pcWrite pcWriteCond
  // pcSource[2] regWrite regDst memToReg aluSrcA aluSrcB[2] aluOp[2] illegalOp
  function automatic logic [17:0] mk(
    input logic rq, input logic rd, input logic wr, input logic io,
    input logic ir, input logic pw, input logic pc, input logic [1:0] ps,
    input logic rw, input logic dst, input logic m2r, input logic sa,
    input logic [1:0] sb, input logic [1:0] ao, input logic il);
    return {rq, rd, wr, io, ir, pw, pc, ps, rw, dst, m2r, sa, sb, ao, il};
  endfunction

  localparam logic [17:0] E_IDLE     = 18'd0;
  localparam logic [17:0] E_FETCH_W  = mk(1'b1,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,1'b0,1'b0,1'b0,1'b0,2'b01,2'b00,1'b0);
  localparam logic [17:0] E_FETCH_R  = mk(1'b1,1'b1,1'b0,1'b0,1'b1,1'b1,1'b0,2'b00,1'b0,1'b0,1'b0,1'b0,2'b01,2'b00,1'b0);
  localparam logic [17:0] E_DECODE   = mk(1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,1'b0,1'b0,1'b0,1'b0,2'b11,2'b00,1'b0);
  localparam logic [17:0] E_DEC_ILL  = mk(1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,1'b0,1'b0,1'b0,1'b0,2'b11,2'b00,1'b1);
  localparam logic [17:0] E_EXEC_R   = mk(1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,1'b0,1'b0,1'b0,1'b1,2'b00,2'b10,1'b0);
  localparam logic [17:0] E_EXEC_A   = mk(1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,1'b0,1'b0,1'b0,1'b1,2'b10,2'b00,1'b0);
  localparam logic [17:0] E_MEM_LW   = mk(1'b1,1'b1,1'b0,1'b1,1'b0,1'b0,1'b0,2'b00,1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,1'b0);
  localparam logic [17:0] E_MEM_SW   = mk(1'b1,1'b0,1'b1,1'b1,1'b0,1'b0,1'b0,2'b00,1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,1'b0);
  localparam logic [17:0] E_WB_R     = mk(1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,1'b1,1'b1,1'b0,1'b0,2'b00,2'b00,1'b0);
  localparam logic [17:0] E_WB_I     = mk(1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,1'b1,1'b0,1'b0,1'b0,2'b00,2'b00,1'b0);
  localparam logic [17:0] E_WB_MEM   = mk(1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,1'b1,1'b0,1'b1,1'b0,2'b00,2'b00,1'b0);
  localparam logic [17:0] E_BRANCH   = mk(1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b01,1'b0,1'b0,1'b0,1'b1,2'b00,2'b01,1'b0);
  localparam logic [17:0] E_JUMP     = mk(1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,2'b10,1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,1'b0);

  typedef struct {
    logic [17:0] cw;
    int          cnt;
    string       name;
  } exp_t;

  exp_t sb_q[$];
  int   total = 0;
  int   bad   = 0;
  int   exp_cnt = 0;

  // Drive one cycle of inputs and record what the DUT must show in that cycle.
  task automatic step(input logic rstn, input logic [5:0] op, input logic rdy,
                      input logic [17:0] e, input bit retires, input string nm);
    exp_t item;
    @(posedge clk);
    #1;
    resetN   = rstn;
    opCode   = op;
    memReady = rdy;
    if (!rstn) exp_cnt = 0;
    item.cw   = e;
    item.cnt  = exp_cnt;
    item.name = nm;
    sb_q.push_back(item);
    if (retires) exp_cnt = exp_cnt + 1;
  endtask

  // Monitor: compare every cycle's outputs against the oldest expectation.
  always @(negedge clk) begin
    if (sb_q.size() != 0) begin
      exp_t e;
      logic [17:0] got;
      e = sb_q.pop_front();
      got = {memReq, memRead, memWrite, iorD, irWrite, pcWrite, pcWriteCond, pcSource,
             regWrite, regDst, memToReg, aluSrcA, aluSrcB, aluOp, illegalOp};
      total = total + 1;
      if (got !== e.cw) begin
        bad = bad + 1;
        $display("FAIL %s ctrl got=%05h exp=%05h", e.name, got, e.cw);
      end
`ifdef INSTR_COUNT_EN
      total = total + 1;
      if (retiredCount !== 32'(e.cnt)) begin
        bad = bad + 1;
        $display("FAIL %s retiredCount got=%0d exp=%0d", e.name, retiredCount, e.cnt);
      end
`endif
    end
  end

  initial begin
    resetN   = 1'b0;
    opCode   = 6'd0;
    memReady = 1'b0;
    step(1'b0, 6'd0, 1'b0, E_IDLE, 1'b0, "reset");
    step(1'b1, 6'd0, 1'b0, E_IDLE, 1'b0, "idle");
    // LW with two MEM stalls
    step(1'b1, 6'd1, 1'b1, E_FETCH_R, 1'b0, "lw_fetch");
    step(1'b1, 6'd1, 1'b1, E_DECODE,  1'b0, "lw_decode");
    step(1'b1, 6'd1, 1'b1, E_EXEC_A,  1'b0, "lw_exec");
    step(1'b1, 6'd1, 1'b0, E_MEM_LW,  1'b0, "lw_mem0");
    step(1'b1, 6'd1, 1'b0, E_MEM_LW,  1'b0, "lw_mem1");
    step(1'b1, 6'd1, 1'b1, E_MEM_LW,  1'b0, "lw_mem2");
    step(1'b1, 6'd1, 1'b1, E_WB_MEM,  1'b1, "lw_wb");
    // R-type
    step(1'b1, 6'd0, 1'b1, E_FETCH_R, 1'b0, "r_fetch");
    step(1'b1, 6'd0, 1'b1, E_DECODE,  1'b0, "r_decode");
    step(1'b1, 6'd0, 1'b1, E_EXEC_R,  1'b0, "r_exec");
    step(1'b1, 6'd0, 1'b1, E_WB_R,    1'b1, "r_wb");
    // BEQ, memReady low where it must be ignored
    step(1'b1, 6'd3, 1'b1, E_FETCH_R, 1'b0, "beq_fetch");
    step(1'b1, 6'd3, 1'b0, E_DECODE,  1'b0, "beq_decode");
    step(1'b1, 6'd3, 1'b0, E_BRANCH,  1'b1, "beq_branch");
    // J then SW
    step(1'b1, 6'd5, 1'b1, E_FETCH_R, 1'b0, "j_fetch");
    step(1'b1, 6'd5, 1'b1, E_DECODE,  1'b0, "j_decode");
    step(1'b1, 6'd5, 1'b1, E_JUMP,    1'b1, "j_jump");
    step(1'b1, 6'd2, 1'b1, E_FETCH_R, 1'b0, "sw_fetch");
    step(1'b1, 6'd2, 1'b1, E_DECODE,  1'b0, "sw_decode");
    step(1'b1, 6'd2, 1'b1, E_EXEC_A,  1'b0, "sw_exec");
    step(1'b1, 6'd2, 1'b1, E_MEM_SW,  1'b1, "sw_mem");
    // ADDI with one FETCH stall
    step(1'b1, 6'd4, 1'b0, E_FETCH_W, 1'b0, "addi_fetch_wait");
    step(1'b1, 6'd4, 1'b1, E_FETCH_R, 1'b0, "addi_fetch");
    step(1'b1, 6'd4, 1'b1, E_DECODE,  1'b0, "addi_decode");
    step(1'b1, 6'd4, 1'b1, E_EXEC_A,  1'b0, "addi_exec");
    step(1'b1, 6'd4, 1'b1, E_WB_I,    1'b1, "addi_wb");
    // Illegal opcode: one-cycle flag, straight back to FETCH, not counted
    step(1'b1, 6'h3F, 1'b1, E_FETCH_R, 1'b0, "ill_fetch");
    step(1'b1, 6'h3F, 1'b1, E_DEC_ILL, 1'b0, "ill_decode");
    step(1'b1, 6'h3F, 1'b0, E_FETCH_W, 1'b0, "ill_refetch");
    // SW interrupted by reset while writing memory
    step(1'b1, 6'd2, 1'b1, E_FETCH_R, 1'b0, "swr_fetch");
    step(1'b1, 6'd2, 1'b1, E_DECODE,  1'b0, "swr_decode");
    step(1'b1, 6'd2, 1'b1, E_EXEC_A,  1'b0, "swr_exec");
    step(1'b1, 6'd2, 1'b0, E_MEM_SW,  1'b0, "swr_mem");
    step(1'b0, 6'd2, 1'b0, E_IDLE,    1'b0, "swr_async_reset");
    step(1'b0, 6'd2, 1'b0, E_IDLE,    1'b0, "swr_reset_hold");
    step(1'b1, 6'd0, 1'b1, E_IDLE,    1'b0, "post_idle");
    step(1'b1, 6'd0, 1'b1, E_FETCH_R, 1'b0, "post_fetch");
    step(1'b1, 6'd0, 1'b1, E_DECODE,  1'b0, "post_decode");
    step(1'b1, 6'd0, 1'b1, E_EXEC_R,  1'b0, "post_exec");
    step(1'b1, 6'd0, 1'b1, E_WB_R,    1'b1, "post_wb");
    step(1'b1, 6'd0, 1'b0, E_FETCH_W, 1'b0, "post_refetch");
    for (int i = 0; i < 10 && sb_q.size() != 0; i++) @(negedge clk);
    @(posedge clk);
    if (sb_q.size() != 0) begin
      bad = bad + 1;
      $display("FAIL drain pending=%0d required=0", sb_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
